// File: rtl/nios_handshake_onchip_ram_dp_if.sv
// One Avalon-MM slave port of the dual-slave on-chip RAM.
// The master modport drives commands; the slave modport returns stall and read data.
interface nios_handshake_onchip_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_handshake_onchip_ram_dp.sv
// Dual-slave on-chip RAM: s1 (CPU) and s2 (accelerator) share one array, old-data reads,
// pipelined readdatavalid, and s1 priority on a same-address write collision.
module nios_handshake_onchip_ram_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clken,
    input  logic                            reset_req,
    nios_handshake_onchip_ram_dp_if.slave   s1,
    nios_handshake_onchip_ram_dp_if.slave   s2
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("nios_handshake_onchip_ram_dp: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                        w_freeze;
    logic                        w_collide;
    logic [1:0]                  w_cs, w_rd, w_wr;
    logic [1:0]                  w_acc_rd, w_acc_wr;
    logic [1:0][ADDR_WIDTH-1:0]  w_addr;
    logic [1:0][NB-1:0]          w_be;
    logic [1:0][DATA_WIDTH-1:0]  w_wdata;
    logic                        w_rvalid [2];
    logic [DATA_WIDTH-1:0]       w_rdata  [2];

    assign w_cs    = {s2.chipselect, s1.chipselect};
    assign w_rd    = {s2.read,       s1.read};
    assign w_wr    = {s2.write,      s1.write};
    assign w_addr  = {s2.address,    s1.address};
    assign w_be    = {s2.byteenable, s1.byteenable};
    assign w_wdata = {s2.writedata,  s1.writedata};

    assign w_freeze  = ~clken | reset_req;
    assign w_collide = w_cs[0] & w_wr[0] & w_cs[1] & w_wr[1] & (w_addr[0] == w_addr[1]);

    assign s1.waitrequest = w_freeze;
    assign s2.waitrequest = w_freeze | w_collide;

    // Write beats a simultaneous read on the same port; s2 write yields to s1 on collision.
    assign w_acc_wr[0] = ~w_freeze & w_cs[0] & w_wr[0];
    assign w_acc_wr[1] = ~w_freeze & w_cs[1] & w_wr[1] & ~w_collide;
    assign w_acc_rd    = {2{~w_freeze}} & w_cs & w_rd & ~w_wr;

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_acc_wr[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_be[p][b]) r_mem[w_addr[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  r_vld1;
        logic [DATA_WIDTH-1:0] r_dat1;

        // Array read shares the write edge, so a same-address write is not yet visible.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld1 <= 1'b0;
                r_dat1 <= '0;
            end else if (!w_freeze) begin
                r_vld1 <= w_acc_rd[p];
                if (w_acc_rd[p]) r_dat1 <= r_mem[w_addr[p]];
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_vld2;
            logic [DATA_WIDTH-1:0] r_dat2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else if (!w_freeze) begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) r_dat2 <= r_dat1;
                end
            end

            assign w_rvalid[p] = r_vld2;
            assign w_rdata[p]  = r_dat2;
        end else begin : g_lat1
            assign w_rvalid[p] = r_vld1;
            assign w_rdata[p]  = r_dat1;
        end
    end

    assign s1.readdatavalid = w_rvalid[0];
    assign s1.readdata      = w_rdata[0];
    assign s2.readdatavalid = w_rvalid[1];
    assign s2.readdata      = w_rdata[1];
endmodule
